// File: rtl/sb_at_pkg.sv
// Shared definitions for the sideband AT requester: FSM encoding, CTRL byte layout,
// frame byte indices and length helpers.
package sb_at_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } at_state_e;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DATA_W     = 24;
    localparam int unsigned LEN_W      = 2;
    localparam int unsigned AT_LEN_MAX = 3;
    localparam int unsigned IDX_W      = 3;

    // CTRL byte layout
    localparam int unsigned WR_BIT  = 7;
    localparam int unsigned LEN_LSB = 0;

    localparam logic [IDX_W-1:0] IDX_ADDR  = 3'd0;
    localparam logic [IDX_W-1:0] IDX_CTRL  = 3'd1;
    localparam logic [IDX_W-1:0] IDX_DATA0 = 3'd2;
    localparam logic [IDX_W-1:0] IDX_DATA1 = 3'd3;
    localparam logic [IDX_W-1:0] IDX_DATA2 = 3'd4;

    // A length field of 0 means the maximum byte count.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(AT_LEN_MAX) : len;
    endfunction

    function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        case (len)
            2'd1:    return 24'h0000FF;
            2'd2:    return 24'h00FFFF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

endpackage

// File: rtl/sb_at_frame_ser.sv
// AT request frame serializer: ADDR, CTRL, write DATA bytes, then XOR checksum,
// over a valid/ready byte stream. last_sent_c pulses on the checksum handshake.
module sb_at_frame_ser
    import sb_at_pkg::*;
(
    input  logic                fsm_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                frm_write,
    input  logic [BYTE_W-1:0]   frm_addr,
    input  logic [LEN_W-1:0]    frm_len,
    input  logic [DATA_W-1:0]   frm_wdata,
    input  logic                tx_ready,
    output logic [BYTE_W-1:0]   tx_byte,
    output logic                tx_valid,
    output logic                last_sent_c
);

    logic [IDX_W-1:0]  idx;
    logic              wr_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BYTE_W-1:0] chk_q;

    logic              take_c;
    logic [IDX_W-1:0]  idx_nxt_c;
    logic [IDX_W-1:0]  last_idx_c;
    logic [BYTE_W-1:0] chk_nxt_c;
    logic [BYTE_W-1:0] ctrl_c;
    logic [BYTE_W-1:0] nxt_byte_c;

    assign take_c      = tx_valid & tx_ready;
    assign idx_nxt_c   = idx + 1'b1;
    assign last_idx_c  = wr_q ? (IDX_DATA0 + IDX_W'(len_q)) : IDX_DATA0;
    assign chk_nxt_c   = chk_q ^ tx_byte;
    assign last_sent_c = take_c && (idx == last_idx_c);

    always_comb begin
        ctrl_c                      = '0;
        ctrl_c[WR_BIT]              = wr_q;
        ctrl_c[LEN_LSB +: LEN_W]    = len_q;
    end

    // Byte presented after the current one is consumed; checksum closes the frame.
    always_comb begin
        nxt_byte_c = chk_nxt_c;
        if (idx_nxt_c != last_idx_c) begin
            case (idx_nxt_c)
                IDX_CTRL:  nxt_byte_c = ctrl_c;
                IDX_DATA0: nxt_byte_c = wdata_q[7:0];
                IDX_DATA1: nxt_byte_c = wdata_q[15:8];
                IDX_DATA2: nxt_byte_c = wdata_q[23:16];
                default:   nxt_byte_c = chk_nxt_c;
            endcase
        end
    end

    always_ff @(posedge fsm_clk) begin
        if (rst) begin
            idx      <= IDX_ADDR;
            wr_q     <= 1'b0;
            len_q    <= '0;
            wdata_q  <= '0;
            chk_q    <= '0;
            tx_byte  <= '0;
            tx_valid <= 1'b0;
        end else if (start) begin
            idx      <= IDX_ADDR;
            wr_q     <= frm_write;
            len_q    <= frm_len;
            wdata_q  <= frm_wdata;
            chk_q    <= '0;
            tx_byte  <= frm_addr;
            tx_valid <= 1'b1;
        end else if (take_c) begin
            if (last_sent_c) begin
                tx_valid <= 1'b0;
                idx      <= IDX_ADDR;
                chk_q    <= '0;
            end else begin
                idx      <= idx_nxt_c;
                chk_q    <= chk_nxt_c;
                tx_byte  <= nxt_byte_c;
            end
        end
    end

endmodule

// File: rtl/sb_at_requester.sv
// Sideband AT requester: accepts one register command, sends the AT frame, waits for the
// matching response or a timeout. Define AT_RETRY_EN to retransmit on timeout up to MAX_RETRY times.
module sb_at_requester
    import sb_at_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                fsm_clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [BYTE_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic [BYTE_W-1:0]   tx_byte,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic                rsp_valid,
    input  logic [BYTE_W-1:0]   rsp_addr,
    input  logic [DATA_W-1:0]   rsp_data,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   rd_data,
    output logic                busy
);

    localparam int unsigned     TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    if (TIMEOUT_CYC < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYC must be at least 2");
    end
    if (MAX_RETRY > 7) begin : g_retry_chk
        $error("MAX_RETRY exceeds the retry counter range");
    end

    at_state_e          state;
    logic               wr_q;
    logic [BYTE_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [TMR_W-1:0]   timer;
    logic               rsp_hit;

    logic               accept_c;
    logic               match_c;
    logic               timeout_c;
    logic               retry_c;
    logic               last_sent_c;

    logic               ser_write_c;
    logic [BYTE_W-1:0]  ser_addr_c;
    logic [LEN_W-1:0]   ser_len_c;
    logic [DATA_W-1:0]  ser_wdata_c;

    assign accept_c  = cmd_valid & cmd_ready;
    assign match_c   = (state == ST_WAIT_RSP) && !rsp_hit && rsp_valid && (rsp_addr == addr_q);
    assign timeout_c = (state == ST_WAIT_RSP) && !rsp_hit && !match_c && (timer == TMR_LAST);

`ifdef AT_RETRY_EN
    localparam int unsigned RETRY_W = 3;
    logic [RETRY_W-1:0] retry_cnt;
    assign retry_c = timeout_c && (32'(retry_cnt) < MAX_RETRY);
`else
    assign retry_c = 1'b0;
`endif

    // A retry replays the latched command, so the frame is identical.
    assign ser_write_c = accept_c ? cmd_write         : wr_q;
    assign ser_addr_c  = accept_c ? cmd_addr          : addr_q;
    assign ser_len_c   = accept_c ? eff_len(cmd_len)  : len_q;
    assign ser_wdata_c = accept_c ? cmd_wdata         : wdata_q;

    sb_at_frame_ser u_ser (
        .fsm_clk     (fsm_clk),
        .rst         (rst),
        .start       (accept_c | retry_c),
        .frm_write   (ser_write_c),
        .frm_addr    (ser_addr_c),
        .frm_len     (ser_len_c),
        .frm_wdata   (ser_wdata_c),
        .tx_ready    (tx_ready),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .last_sent_c (last_sent_c)
    );

    // A matching response is registered first, then closes the transaction next cycle.
    always_ff @(posedge fsm_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_data   <= '0;
            busy      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            timer     <= '0;
            rsp_hit   <= 1'b0;
`ifdef AT_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        state     <= ST_SEND;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        rd_data   <= '0;
                        wr_q      <= cmd_write;
                        addr_q    <= cmd_addr;
                        len_q     <= eff_len(cmd_len);
                        wdata_q   <= cmd_wdata;
                        timer     <= '0;
                        rsp_hit   <= 1'b0;
`ifdef AT_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                ST_SEND: begin
                    if (last_sent_c) begin
                        state <= ST_WAIT_RSP;
                        timer <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_hit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (match_c) begin
                        rsp_hit <= 1'b1;
                        if (!wr_q) begin
                            rd_data <= rsp_data & len_mask(len_q);
                        end
                    end else if (timeout_c) begin
                        if (retry_c) begin
                            state <= ST_SEND;
`ifdef AT_RETRY_EN
                            if (retry_cnt != '1) begin
                                retry_cnt <= retry_cnt + 1'b1;
                            end
`endif
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end else if (timer != TMR_LAST) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sb_at_requester.sv
// Directed bench for sb_at_requester (TIMEOUT_CYC = 16, MAX_RETRY = 3); honours AT_RETRY_EN.
module tb_sb_at_requester;

    logic        fsm_clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [1:0]  cmd_len;
    logic [23:0] cmd_wdata;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_addr;
    logic [23:0] rsp_data;
    logic        done;
    logic        err;
    logic [23:0] rd_data;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    sb_at_requester #(.TIMEOUT_CYC(16), .MAX_RETRY(3)) dut (
        .fsm_clk   (fsm_clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .done      (done),
        .err       (err),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    always #5 fsm_clk = ~fsm_clk;

    task automatic step();
        @(posedge fsm_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [1:0] len,
                         input logic [23:0] wdata);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Records handshaken bytes until tx_valid drops; returns in the first cycle after the last byte.
    task automatic get_frame(output int n, output logic [7:0] fb [8]);
        n = 0;
        for (int i = 0; i < 8; i++) fb[i] = 8'h00;
        for (int c = 0; c < 60; c++) begin
            if (tx_valid && tx_ready) begin
                if (n < 8) fb[n] = tx_byte;
                n++;
            end
            step();
            if (!tx_valid && n > 0) break;
        end
    endtask

    task automatic check_frame(input string tag, input int n, input logic [7:0] fb [8],
                               input int n_exp, input logic [7:0] exp [8]);
        check({tag, "_len"}, 32'(n), 32'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(fb[i]), 32'(exp[i]));
        end
    endtask

    task automatic respond(input logic [7:0] addr, input logic [23:0] data);
        rsp_addr  = addr;
        rsp_data  = data;
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
    endtask

    // Called in the cycle after the matching response: done must rise one cycle later.
    task automatic expect_done(input string tag, input logic err_exp, input logic [23:0] rd_exp);
        check({tag, "_done_early"}, 32'(done), 32'd0);
        step();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'(err_exp));
        check({tag, "_rd"}, 32'(rd_data), 32'(rd_exp));
        step();
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          n;
        int          k;
        int          nf;
        logic [7:0]  fb  [8];
        logic [7:0]  exp [8];

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_wdata = '0; tx_ready = 1'b1; rsp_valid = 1'b0; rsp_addr = '0; rsp_data = '0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_txv", 32'(tx_valid), 32'd0);
        check("rst_txb", 32'(tx_byte), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 1: read addr 78
        issue(1'b0, 8'd78, 2'd3, 24'h0);
        check("t1_first_v", 32'(tx_valid), 32'd1);
        check("t1_first_b", 32'(tx_byte), 32'h4E);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_nready", 32'(cmd_ready), 32'd0);
        get_frame(n, fb);
        exp = '{8'h4E, 8'h03, 8'h4D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("t1_frm", n, fb, 3, exp);
        respond(8'd78, 24'h053303);
        expect_done("t1", 1'b0, 24'h053303);

        // 2: write addr 85 len 1
        issue(1'b1, 8'd85, 2'd1, 24'h0000C0);
        get_frame(n, fb);
        exp = '{8'h55, 8'h81, 8'hC0, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("t2_frm", n, fb, 4, exp);
        respond(8'd85, 24'hABCDEF);
        expect_done("t2", 1'b0, 24'h000000);

        // 2b: read of 2 bytes masks byte 2 of the response
        issue(1'b0, 8'h10, 2'd2, 24'h0);
        get_frame(n, fb);
        exp = '{8'h10, 8'h02, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("t2b_frm", n, fb, 3, exp);
        respond(8'h10, 24'hAABBCC);
        expect_done("t2b", 1'b0, 24'h00BBCC);

        // 3: backpressure on byte 1, len 0 means 3
        issue(1'b0, 8'd78, 2'd0, 24'h0);
        check("t3_b0", 32'(tx_byte), 32'h4E);
        step();
        check("t3_b1", 32'(tx_byte), 32'h03);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t3_hold%0d", i), {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, 8'h03});
        end
        tx_ready = 1'b1;
        get_frame(n, fb);
        exp = '{8'h03, 8'h4D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_frame("t3_rest", n, fb, 2, exp);
        respond(8'd78, 24'h123456);
        expect_done("t3", 1'b0, 24'h123456);

        // 4: no response -> timeout (with retries when enabled)
`ifdef AT_RETRY_EN
        nf = 4;
`else
        nf = 1;
`endif
        issue(1'b0, 8'd78, 2'd3, 24'h0);
        exp = '{8'h4E, 8'h03, 8'h4D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int f = 0; f < nf; f++) begin
            get_frame(n, fb);
            check_frame($sformatf("t4_frm%0d", f), n, fb, 3, exp);
            k = 1;
            while (!(done || tx_valid) && k < 100) begin
                step();
                k++;
            end
            check($sformatf("t4_wait%0d", f), 32'(k), 32'd17);
            if (f < nf - 1) check($sformatf("t4_resend%0d", f), 32'(tx_valid), 32'd1);
        end
        check("t4_done", 32'(done), 32'd1);
        check("t4_err", 32'(err), 32'd1);
        check("t4_rd", 32'(rd_data), 32'd0);
        step();
        check("t4_done_drop", 32'(done), 32'd0);
        check("t4_err_hold", 32'(err), 32'd1);

        // 5: mismatched address ignored, then match; accept clears err
        issue(1'b0, 8'd78, 2'd3, 24'h0);
        check("t5_err_clr", 32'(err), 32'd0);
        get_frame(n, fb);
        respond(8'd79, 24'h00FFFF);
        step();
        check("t5_ignored", 32'(done), 32'd0);
        respond(8'd78, 24'h000001);
        expect_done("t5", 1'b0, 24'h000001);

        // 5b: match on the timeout cycle wins
        issue(1'b0, 8'd78, 2'd3, 24'h0);
        get_frame(n, fb);
        repeat (15) step();
        respond(8'd78, 24'h00AA55);
        expect_done("t5b", 1'b0, 24'h00AA55);

        // 6: reset during byte 1, stray response in IDLE, then a clean read
        issue(1'b0, 8'd78, 2'd3, 24'h0);
        step();
        check("t6_b1", 32'(tx_byte), 32'h03);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_txv", 32'(tx_valid), 32'd0);
        check("t6_ready", 32'(cmd_ready), 32'd1);
        check("t6_done", 32'(done), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        respond(8'd78, 24'h111111);
        step();
        check("t6_stray", {30'd0, done, busy}, 32'd0);
        issue(1'b0, 8'd78, 2'd3, 24'h0);
        get_frame(n, fb);
        check_frame("t6_frm", n, fb, 3, exp);
        respond(8'd78, 24'h053303);
        expect_done("t6", 1'b0, 24'h053303);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
